gesture_eval_scheduler: RTL
===========================

# gesture_eval_scheduler

Sequences the voxel-bin gesture pipeline over fixed time windows. On each window boundary it hands the accumulator bins to the feature extractor through a snapshot handshake and waits for the extracted features. It then issues the single-cycle classification strobe (with the minimum-activity pass flag) to the persistence classifier, and finally sweeps the bin memory to clear or decay it for the next window. It sits between the event front-end / bin accumulator and the gesture classifier.

## Interface
- WINDOW_CYCLES, 1200000: window length in clk cycles (≥ NUM_BINS+8)
- NUM_BINS, 16: bin memory depth swept after each evaluation
- BIN_ADDR_W, 4: clog2(NUM_BINS)
- EVT_CNT_BITS, 16: event counter width
- MIN_EVENTS, 20: minimum events per window for eval_pass=1
- FEAT_TIMEOUT, 64: max cycles from snap_ack to feat_done
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run scheduler; low forces return to IDLE at next cycle
- event_in  in  1  one-cycle pulse per accepted event
- snap_req  out  1  request accumulator snapshot; held until snap_ack
- snap_ack  in  1  snapshot taken (one cycle)
- feat_done  in  1  extractor finished (one cycle)
- eval_valid  out  1  one-cycle strobe to classifier class_valid
- eval_pass  out  1  window_events ≥ MIN_EVENTS; valid with eval_valid
- bin_op  out  2  00 none, 01 clear, 10 halve; valid during sweep
- bin_addr  out  BIN_ADDR_W  sweep address
- window_events  out  EVT_CNT_BITS  event count latched at last window end
- overrun  out  1  sticky: window tick arrived outside ACCUM
- feat_timeout  out  1  sticky: FEAT_TIMEOUT expired

## Operation
- States: IDLE, ACCUM, SNAP, WAIT_FEAT, EVAL, SWEEP.
- IDLE: timer and counter held at 0; enable=1 → ACCUM.
- Window timer counts 0..WINDOW_CYCLES-1 while enable, wraps; tick = timer at WINDOW_CYCLES-1.
- Event counter saturates at all-ones. On tick: window_events ← count (including event_in that cycle); count ← 0.
- ACCUM + tick → SNAP. Tick in any other state: tick dropped, overrun←1, event count still latched/reset.
- SNAP: snap_req=1 until snap_ack sampled high → WAIT_FEAT (snap_req deasserts same edge).
- WAIT_FEAT: feat_done → EVAL; FEAT_TIMEOUT cycles elapsed without it → SWEEP, feat_timeout←1, no eval strobe.
- EVAL: eval_valid=1 one cycle, eval_pass = (window_events ≥ MIN_EVENTS) → SWEEP.
- SWEEP: bin_addr 0..NUM_BINS-1, one per cycle, bin_op per Configuration; after last address → ACCUM, bin_op=00.
- Events are counted in every non-IDLE state (they belong to the current window).
- enable=0 in any state → IDLE next cycle; snap_req, eval_valid, bin_op drop immediately; sticky flags kept. Sticky flags clear only on reset.

## Timing
- Reset (rst_n low, async): state IDLE, snap_req 0, eval_valid 0, eval_pass 0, bin_op 00, bin_addr 0, window_events 0, overrun 0, feat_timeout 0, counters 0.
- All outputs registered.
- snap_req rises the cycle after tick. eval_valid asserts the cycle after feat_done is sampled. First sweep cycle is the cycle after eval_valid; sweep lasts exactly NUM_BINS cycles.
- snap_ack and feat_done are sampled only in their own states. If both arrive in the same cycle in SNAP, feat_done is ignored.

## Configuration
- GESTURE_SCHED_DECAY_EN undefined: bin_op = 01 (clear) for every sweep.
- GESTURE_SCHED_DECAY_EN defined: bin_op = 10 (halve) when the window just evaluated had eval_pass=1. A failed pass or a timeout uses 01 (clear). This retains a decaying history across active windows.

## Test plan
- WINDOW_CYCLES=100, 25 events, snap_ack 2 cycles after req, feat_done 5 later → window_events=25, one eval_valid with eval_pass=1, 16 sweep cycles with bin_op=01, addr 0..15, return to ACCUM.
- 19 events in window → eval_pass=0; with GESTURE_SCHED_DECAY_EN, sweep uses 01; with 20 events, sweep uses 10.
- feat_done withheld → feat_timeout=1 exactly FEAT_TIMEOUT cycles after snap_ack, no eval_valid, sweep runs.
- snap_ack withheld past next tick → overrun=1, snap_req stays high, window_events updated to new count.
- enable dropped mid-SWEEP at addr 7 → bin_op=00 and IDLE next cycle; re-enable restarts timer from 0.
- rst_n asserted mid-WAIT_FEAT (async, between edges) → all outputs at reset values immediately, sticky flags cleared.

Source files
------------

// File: rtl/gesture_eval_scheduler.sv
// Window scheduler for the voxel-bin gesture pipeline: snapshot, feature wait, eval strobe, bin sweep.
// Optional build macro GESTURE_SCHED_DECAY_EN: sweep halves bins after a passing window instead of clearing.
module gesture_eval_scheduler #(
  parameter int unsigned WINDOW_CYCLES = 1200000,
  parameter int unsigned NUM_BINS      = 16,
  parameter int unsigned BIN_ADDR_W    = 4,
  parameter int unsigned EVT_CNT_BITS  = 16,
  parameter int unsigned MIN_EVENTS    = 20,
  parameter int unsigned FEAT_TIMEOUT  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    event_in,
  output logic                    snap_req,
  input  logic                    snap_ack,
  input  logic                    feat_done,
  output logic                    eval_valid,
  output logic                    eval_pass,
  output logic [1:0]              bin_op,
  output logic [BIN_ADDR_W-1:0]   bin_addr,
  output logic [EVT_CNT_BITS-1:0] window_events,
  output logic                    overrun,
  output logic                    feat_timeout
);

  localparam int unsigned TIMER_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned FT_W    = $clog2(FEAT_TIMEOUT + 1);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_HALVE = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCUM     = 3'd1,
    SNAP      = 3'd2,
    WAIT_FEAT = 3'd3,
    EVAL      = 3'd4,
    SWEEP     = 3'd5
  } state_t;

  state_t                  state, state_d;
  logic [TIMER_W-1:0]      timer, timer_d;
  logic [EVT_CNT_BITS-1:0] evt_cnt, evt_cnt_d, evt_inc;
  logic [FT_W-1:0]         feat_cnt, feat_cnt_d;
  logic                    tick;

  logic                    snap_req_d, eval_valid_d, eval_pass_d;
  logic [1:0]              bin_op_d;
  logic [BIN_ADDR_W-1:0]   bin_addr_d;
  logic [EVT_CNT_BITS-1:0] window_events_d;
  logic                    overrun_d, feat_timeout_d;

  // State, counters and every output are registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      evt_cnt       <= '0;
      feat_cnt      <= '0;
      snap_req      <= 1'b0;
      eval_valid    <= 1'b0;
      eval_pass     <= 1'b0;
      bin_op        <= OP_NONE;
      bin_addr      <= '0;
      window_events <= '0;
      overrun       <= 1'b0;
      feat_timeout  <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      evt_cnt       <= evt_cnt_d;
      feat_cnt      <= feat_cnt_d;
      snap_req      <= snap_req_d;
      eval_valid    <= eval_valid_d;
      eval_pass     <= eval_pass_d;
      bin_op        <= bin_op_d;
      bin_addr      <= bin_addr_d;
      window_events <= window_events_d;
      overrun       <= overrun_d;
      feat_timeout  <= feat_timeout_d;
    end
  end

  // Next state, window bookkeeping and next output values
  always_comb begin
    state_d         = state;
    timer_d         = timer;
    evt_cnt_d       = evt_cnt;
    feat_cnt_d      = '0;
    tick            = 1'b0;
    snap_req_d      = 1'b0;
    eval_valid_d    = 1'b0;
    eval_pass_d     = 1'b0;
    bin_op_d        = OP_NONE;
    bin_addr_d      = '0;
    window_events_d = window_events;
    overrun_d       = overrun;
    feat_timeout_d  = feat_timeout;
    evt_inc         = (evt_cnt == '1) ? evt_cnt : evt_cnt + EVT_CNT_BITS'(1);

    if (!enable || state == IDLE) begin
      timer_d   = '0;
      evt_cnt_d = '0;
      state_d   = enable ? ACCUM : IDLE;
    end else begin
      tick      = (timer == TIMER_W'(WINDOW_CYCLES - 1));
      timer_d   = tick ? '0 : timer + TIMER_W'(1);
      evt_cnt_d = event_in ? evt_inc : evt_cnt;

      // The tick-cycle event still belongs to the closing window
      if (tick) begin
        window_events_d = evt_cnt_d;
        evt_cnt_d       = '0;
        if (state != ACCUM) overrun_d = 1'b1;
      end

      case (state)
        ACCUM: if (tick) state_d = SNAP;
        SNAP:  if (snap_ack) state_d = WAIT_FEAT;
        WAIT_FEAT: begin
          if (feat_done) begin
            state_d = EVAL;
          end else if (feat_cnt == FT_W'(FEAT_TIMEOUT - 1)) begin
            state_d        = SWEEP;
            feat_timeout_d = 1'b1;
          end else begin
            feat_cnt_d = feat_cnt + FT_W'(1);
          end
        end
        EVAL:  state_d = SWEEP;
        SWEEP: begin
          if (bin_addr == BIN_ADDR_W'(NUM_BINS - 1)) state_d = ACCUM;
          else bin_addr_d = bin_addr + BIN_ADDR_W'(1);
        end
        default: state_d = IDLE;
      endcase

      snap_req_d   = (state_d == SNAP);
      eval_valid_d = (state_d == EVAL);
      eval_pass_d  = (state_d == EVAL) && (window_events >= EVT_CNT_BITS'(MIN_EVENTS));

      // Sweep op is chosen on entry and held for the whole sweep
      if (state_d == SWEEP) begin
        if (state == SWEEP) begin
          bin_op_d = bin_op;
        end else if (state == EVAL) begin
`ifdef GESTURE_SCHED_DECAY_EN
          bin_op_d = eval_pass ? OP_HALVE : OP_CLEAR;
`else
          bin_op_d = OP_CLEAR;
`endif
        end else begin
          bin_op_d = OP_CLEAR;
        end
      end
    end
  end

endmodule
